// File: rtl/projectile_pool.sv
// Pool of vertical projectiles: spawns on fire edges, steps each frame, retires on hit/exit/round end.
// Optional build macro PROJ_COOLDOWN_EN adds a frame-based cooldown between accepted spawns.
module projectile_pool #(
    parameter int NUM_SLOTS       = 4,
    parameter int DIR_UP          = 1,
    parameter int STEP            = 4,
    parameter int START_Y         = 440,
    parameter int LIMIT_Y         = 480,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame,
    input  logic                   fire,
    input  logic [9:0]             spawn_x,
    input  logic [NUM_SLOTS-1:0]   collision,
    input  logic                   done,
    output logic [NUM_SLOTS-1:0]   active,
    output logic [10*NUM_SLOTS-1:0] proj_x,
    output logic [10*NUM_SLOTS-1:0] proj_y,
    output logic                   full,
    output logic                   fired
);

    localparam logic [NUM_SLOTS-1:0] ONE = NUM_SLOTS'(1);

    logic                 fire_q;
    logic                 cool_ok;
    logic                 spawn_ok;
    logic [NUM_SLOTS-1:0] grant;
    logic [NUM_SLOTS-1:0] exits;
    logic [9:0]           y_next [NUM_SLOTS];
    logic [9:0]           y_cur;

    assign full = &active;

    // Lowest clear bit of the registered active vector; slots freed this cycle are not seen.
    assign grant    = ~active & (active + ONE);
    assign spawn_ok = fire & ~fire_q & ~full & ~done & cool_ok;

    // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
    always_comb begin
        exits = '0;
        y_cur = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            y_next[i] = '0;
            y_cur     = proj_y[10*i +: 10];
            if (DIR_UP != 0) begin
                exits[i]  = y_cur < 10'(STEP);
                y_next[i] = y_cur - 10'(STEP);
            end else begin
                exits[i]  = ({1'b0, y_cur} + 11'(STEP)) >= 11'(LIMIT_Y);
                y_next[i] = y_cur + 10'(STEP);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= '0;
            proj_x <= '0;
            proj_y <= '0;
            fired  <= 1'b0;
            fire_q <= 1'b0;
        end else begin
            fire_q <= fire;
            fired  <= spawn_ok;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (done) begin
                    active[i] <= 1'b0;
                end else if (active[i] && collision[i]) begin
                    active[i] <= 1'b0;
                end else if (spawn_ok && grant[i]) begin
                    active[i]           <= 1'b1;
                    proj_x[10*i +: 10]  <= spawn_x;
                    proj_y[10*i +: 10]  <= 10'(START_Y);
                end else if (active[i] && frame) begin
                    if (exits[i]) begin
                        active[i] <= 1'b0;
                    end else begin
                        proj_y[10*i +: 10] <= y_next[i];
                    end
                end
            end
        end
    end

`ifdef PROJ_COOLDOWN_EN
    localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    logic [CW-1:0] cooldown;

    assign cool_ok = (cooldown == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cooldown <= '0;
        end else if (spawn_ok) begin
            cooldown <= CW'(COOLDOWN_FRAMES);
        end else if (frame && cooldown != '0) begin
            cooldown <= cooldown - 1'b1;
        end
    end
`else
    logic unused_cooldown_cfg;

    assign cool_ok             = 1'b1;
    assign unused_cooldown_cfg = (COOLDOWN_FRAMES != 0);
`endif

endmodule

// File: doc/projectile_pool.md
# projectile_pool

Parametrised pool of up to NUM_SLOTS simultaneous vertical projectiles (player lasers or invader bombs) sharing one spawn column source. Allocates a free slot on each rising edge of the fire request, advances every live projectile once per frame, and retires projectiles on collision, screen exit or round end. Sits between input debounce / invader logic and the renderer and collision detectors, replacing the single-shot laser logic.

## Interface
- NUM_SLOTS, 4: number of projectile slots (1..16).
- DIR_UP, 1: 1 = move toward y=0 (player laser); 0 = move toward LIMIT_Y (bomb).
- STEP, 4: pixels moved per frame (1..63).
- START_Y, 440: y loaded into a newly spawned slot.
- LIMIT_Y, 480: exclusive bottom bound for downward projectiles.
- COOLDOWN_FRAMES, 8: frames between accepted spawns (PROJ_COOLDOWN_EN only).

- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- frame  in  1  one-cycle pulse at start of blanking interval.
- fire  in  1  debounced fire level; spawn on rising edge only.
- spawn_x  in  10  x of new projectile (caller applies centring).
- collision  in  NUM_SLOTS  per-slot hit; bit i retires slot i.
- done  in  1  round over; retires all slots.
- active  out  NUM_SLOTS  slot i live.
- proj_x  out  10*NUM_SLOTS  slot i x at bits [10i+9:10i].
- proj_y  out  10*NUM_SLOTS  slot i y, same packing.
- full  out  1  all slots live (combinational from active).
- fired  out  1  one-cycle pulse, spawn accepted.

## Operation
- Reset: active=0, proj_x=0, proj_y=0, fired=0, fire_q=0, cooldown=0.
- Edge detect: fire_q registers fire; spawn request = fire & ~fire_q. Held fire produces exactly one request.
- Allocation: lowest-index slot with active=0 in the registered state. Request while full (or cooling down) is dropped, not queued; fired stays 0.
- Spawn: slot gets active=1, x=spawn_x, y=START_Y; fired=1 for that cycle.
- Move (frame=1), per live slot not spawned this cycle:
  - DIR_UP=1: if y < STEP, retire; else y -= STEP.
  - DIR_UP=0: if y + STEP >= LIMIT_Y (11-bit compare), retire; else y += STEP.
- Retire: active cleared; x,y hold last value (renderer must gate with active).
- Priority per slot, highest first: rst, done, collision[i], spawn, move.
- collision[i] on an inactive slot: ignored.
- Slot freed by collision/move in cycle k is not allocatable until cycle k+1.
- done clears all active and suppresses any spawn that cycle; cooldown and fire_q unaffected.

## Timing
- Spawn latency: fire rising sampled at edge k -> active/x/y/fired visible after edge k (one cycle).
- Movement: frame at edge k -> updated y after edge k; one step per frame pulse, frames assumed at least 2 cycles apart.
- Spawn and frame same cycle: new slot at START_Y unmoved; other slots move.
- Collision and frame same cycle on slot i: retire, no move.
- All outputs registered except full.

## Configuration
- PROJ_COOLDOWN_EN defined: cooldown counter (width clog2(COOLDOWN_FRAMES+1)) loaded with COOLDOWN_FRAMES on accepted spawn, decremented on each frame pulse while nonzero; spawn requests while cooldown != 0 are dropped. done does not clear it.
- Undefined: no counter; spawns limited only by free slots and edge detect; COOLDOWN_FRAMES ignored.

## Test plan
Config NUM_SLOTS=4, DIR_UP=1, STEP=8, START_Y=400 unless noted.
- Reset then idle -> active=0000, all proj_x/proj_y=0, fired=0, full=0.
- fire rises, spawn_x=100, held 20 cycles -> one fired pulse, active=0001, x0=100, y0=400; 3 frames -> y0=376.
- Slot 0 at y=8: frame -> y0=0 still active; next frame -> active[0]=0, y0 holds 0.
- Four fire edges -> active=1111, full=1; fifth edge -> no fired, unchanged; collision=0100 -> 1011; next edge -> slot 2 allocated, 1111.
- active=0001, collision=0001 and fire edge same cycle -> active=0010 (slot 1 allocated, slot 0 retired).
- PROJ_COOLDOWN_EN, COOLDOWN_FRAMES=2: spawn, second edge after 1 frame -> dropped; edge after 2nd frame -> accepted. Without macro: second edge accepted immediately.
